// File: rtl/typing_pkg.sv
// Shared types, constants and the LFSR-to-digit mapping for the typing game engine.
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SCORE_MAX = 4'd15;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Folds the low nibble into 0..9; 10..15 map onto 4..9.
  function automatic logic [3:0] map_digit(input logic [7:0] v);
    logic [3:0] l;
    l = v[3:0];
    return (l >= 4'd10) ? l - 4'd6 : l;
  endfunction

endpackage

// File: rtl/typing_game_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); maximal length, never reaches zero.
module lfsr8
  import typing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], fb};
  end

endmodule

// File: rtl/typing_game_ctrl.sv
// Typing-tutor game engine: button edge detect, one-second tick and IDLE/PLAY/DONE FSM.
// Optional feature: define TYPING_PENALTY_EN to penalise wrong entries.
module typing_game_ctrl
  import typing_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 100_000_000,
  parameter int unsigned GAME_SECONDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       start,
  input  logic       enter,
  output logic [3:0] random_num,
  output logic [3:0] score,
  output logic [3:0] time_left,
  output logic       game_over
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]    GAME_TIME = 4'(GAME_SECONDS);

  logic [7:0]    lfsr_q;
  logic          start_d1, start_d2, enter_d1, enter_d2;
  logic          start_p, enter_p;
  logic [TW-1:0] tick_cnt;
  logic          tick_wrap;
  state_t        state;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Two-stage sync gives a clean one-cycle pulse per press, however long it is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d1 <= 1'b0;
      start_d2 <= 1'b0;
      enter_d1 <= 1'b0;
      enter_d2 <= 1'b0;
    end else begin
      start_d1 <= start;
      start_d2 <= start_d1;
      enter_d1 <= enter;
      enter_d2 <= enter_d1;
    end
  end

  assign start_p   = start_d1 & ~start_d2;
  assign enter_p   = enter_d1 & ~enter_d2;
  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      random_num <= 4'd0;
      score      <= 4'd0;
      time_left  <= GAME_TIME;
      game_over  <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      // NOTE: the default arm keeps an illegal encoding recoverable; flops simply hold otherwise.
      case (state)
        IDLE, DONE: begin
          if (start_p) begin
            state      <= PLAY;
            score      <= 4'd0;
            time_left  <= GAME_TIME;
            tick_cnt   <= '0;
            random_num <= map_digit(lfsr_q);
            game_over  <= 1'b0;
          end
        end

        PLAY: begin
          if (enter_p) begin
            if (sw == random_num) begin
              score      <= (score == SCORE_MAX) ? score : score + 4'd1;
              random_num <= map_digit(lfsr_q);
            end else begin
`ifdef TYPING_PENALTY_EN
              score      <= (score == 4'd0) ? score : score - 4'd1;
              random_num <= map_digit(lfsr_q);
`else
              score      <= score;
`endif
            end
          end

          // A same-cycle entry is scored above; the round closing here does not cancel it.
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (time_left != 4'd0) time_left <= time_left - 4'd1;
            if (time_left <= 4'd1) begin
              state     <= DONE;
              game_over <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/typing_game_ctrl.md
# typing_game_ctrl

Game engine for the typing tutor: picks a random target digit, checks the player's 4-bit switch entry on each Enter press, keeps a saturating score, and counts down the round time in seconds. Outputs `random_num`, `score` and `time_left` drive the 7-segment display stage directly, with no glue logic. The block sits upstream of the display, between the debounced board inputs and the display block.

## Interface
Parameters:
- `TICK_CYCLES`, default 100_000_000: clk cycles per one-second tick. Benches use a small value.
- `GAME_SECONDS`, default 15: round length in seconds. Must be ≤ 15.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `sw`  in  4: player's entered digit.
- `start`  in  1: start button, debounced, level.
- `enter`  in  1: submit button, debounced, level.
- `random_num`  out  4: current target digit, 0–9.
- `score`  out  4: correct-answer count, 0–15.
- `time_left`  out  4: seconds remaining.
- `game_over`  out  1: high in DONE.

## Operation
- FSM states are IDLE, PLAY and DONE.
- **Reset** (synchronous, highest priority, also mid-game) forces:
  - state IDLE; `random_num`=0, `score`=0, `time_left`=GAME_SECONDS, `game_over`=0;
  - tick counter 0, LFSR seed 8'h01, edge-detect registers 0.
- **Edge detection:** `start` and `enter` are registered, and a rising edge gives a one-cycle pulse (`start_p`, `enter_p`). Holding a button produces one pulse only.
- **LFSR:** 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle in every state and never reaches 0.
- **Target mapping:** the target is `l = lfsr[3:0]`; if `l ≥ 10` the target is `l − 6`. The result is always 0–9.
- **IDLE or DONE, on `start_p`:**
  - go to PLAY;
  - `score`←0, `time_left`←GAME_SECONDS, tick counter←0, `random_num`←mapped LFSR, `game_over`←0.
- **PLAY:**
  - The tick counter counts 0..TICK_CYCLES−1. At wrap, `time_left` decrements.
  - When `time_left` goes 1→0, the next state is DONE and `game_over`←1.
  - `start_p` is ignored.
- **PLAY, on `enter_p` with `sw == random_num`:**
  - `score`←min(score+1, 15);
  - `random_num`←mapped LFSR. The new value may repeat the old one.
- **PLAY, on `enter_p` with `sw != random_num`:** behaviour is set by the config macro.
- **DONE:** outputs hold and `enter_p` is ignored. `start_p` starts a new game.
- **Simultaneous events:** an `enter_p` in the same cycle as the final tick is scored first, then the FSM enters DONE.
- **Arithmetic:** all arithmetic is 4-bit unsigned. Score saturates and never wraps. `time_left` never underflows.

## Timing
- Button to pulse: 1 cycle after `start`/`enter` rises.
- Pulse to result: `score`, `random_num` and the state update on the clk edge after the pulse. Total latency from the button edge is 2 cycles.
- Start to first decrement: `time_left` first decrements TICK_CYCLES cycles after the PLAY entry edge. It then decrements every TICK_CYCLES cycles.
- Round length: DONE is entered exactly GAME_SECONDS×TICK_CYCLES cycles after PLAY entry.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: `TYPING_PENALTY_EN`.
- **Defined:** a wrong entry in PLAY does both of the following:
  - `score`←max(score−1, 0);
  - `random_num` reloads from the LFSR.
- **Undefined:** a wrong entry is ignored; score and target are unchanged.

## Structure
- **Package `typing_pkg`** holds:
  - `state_t` enum {IDLE, PLAY, DONE};
  - `SCORE_MAX`=15, `LFSR_SEED`=8'h01;
  - the digit-mapping function.
- **Sub-module `lfsr8`:** holds the free-running LFSR, with ports `clk`, `reset`, `q[7:0]`.
- **Top level:** the edge detectors, tick counter and FSM stay in `typing_game_ctrl`.

## Test plan
- **Reset:** assert `reset` mid-PLAY at `score`=5. Next cycle: IDLE, `score`=0, `time_left`=15, `random_num`=0, `game_over`=0.
- **Correct entry:** TICK_CYCLES=10. Start, set `sw` to `random_num`, pulse `enter` for 1 cycle. Expect `score`=1 two cycles after the rise. `random_num` stays in 0..9.
- **Held button:** hold `enter` high for 20 cycles with a correct `sw`. Expect `score` to increment by 1 only.
- **Saturation and wrong entry:**
  - 17 correct entries give `score`=15.
  - A wrong entry with `TYPING_PENALTY_EN` gives 14.
  - A wrong entry without the macro leaves 15 and the target unchanged.
- **Timeout:** TICK_CYCLES=10, GAME_SECONDS=15.
  - `time_left` reaches 0 and `game_over`=1 exactly 150 cycles after PLAY entry.
  - `enter` in DONE leaves `score` unchanged.
  - A correct `enter_p` in the final-tick cycle is counted.
- **Restart:** `start` in DONE gives `score`=0, `time_left`=15, `game_over`=0. A `start` pulse during PLAY has no effect.
